fp_div_seq: RTL
===============

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 Parameters: none; fixed IEEE-754 single precision.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid  input  1  operand-present strobe; sampled only in IDLE.
REQ-005 float_in_1  input  32  dividend, IEEE-754 single.
REQ-006 float_in_2  input  32  divisor, IEEE-754 single.
REQ-007 error_in  input  1  upstream error flag; captured with the operands.
REQ-008 float_out  output  32  quotient; held until the next completion.
REQ-009 ready  output  1  one-cycle pulse; float_out and error_out are valid in this cycle.
REQ-010 error_out  output  1  result error flag; valid with ready, then held.
REQ-011 busy  output  1  high from the cycle after acceptance through the ready cycle.

Function
REQ-012 The FSM SHALL have states IDLE, UNPACK, DIV, PACK and DONE.
REQ-013 The block SHALL accept an operation at the rising edge where state is IDLE and valid=1, capturing float_in_1, float_in_2 and error_in, then go to UNPACK.
REQ-014 UNPACK SHALL take 1 cycle: split sign/exp/mantissa (hidden 1 restored), classify specials, set e = ea - eb + 127 as a 10-bit signed value, then go to DIV.
REQ-015 DIV SHALL run exactly 25 cycles of radix-2 restoring division, producing Q = floor((Ma<<24)/Mb) as 25 bits, then go to PACK.
REQ-016 PACK SHALL take 1 cycle:
  - Q[24]=1: fraction = Q[23:1], exponent = e.
  - Q[24]=0: fraction = Q[22:0], exponent = e-1.
  - Rounding is truncation (round toward zero).
REQ-017 DONE SHALL last 1 cycle with ready=1, then return to IDLE.
REQ-018 Latency SHALL be fixed: ready asserts exactly 28 cycles after the accepting edge, for every operand class.
REQ-019 A new operation MAY be accepted at the edge ending DONE; valid while busy SHALL be ignored, not queued.
REQ-020 Result sign SHALL be sa XOR sb in all non-NaN cases.
REQ-021 Subnormal inputs SHALL be flushed to signed zero before classification.
REQ-022 Special cases, in priority order:
  - Either input NaN or Inf: 0x7FC00000, error_out=1.
  - Divisor zero with dividend zero: 0x7FC00000, error_out=1.
  - Divisor zero with dividend nonzero: signed Inf, error_out=1.
  - Dividend zero: signed zero.
REQ-023 A final biased exponent >= 255 SHALL give signed Inf (0x7F800000 | sign) with error_out=1.
REQ-024 A final biased exponent <= 0 SHALL give signed zero with error_out not set by this condition.
REQ-025 error_out SHALL be the OR of the captured error_in and every error condition in REQ-022 and REQ-023.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL enter IDLE and set float_out=0, ready=0, error_out=0, busy=0, clearing the iteration counter and datapath registers.
REQ-027 Reset SHALL take priority over valid at the same edge.
REQ-028 Reset during any operation SHALL abort it with no ready pulse.
REQ-029 The first acceptance after reset SHALL be possible at the first edge with rst=0.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
  - 0x40C00000 / 0x40000000 (6/2), error_in=0 -> float_out 0x40400000, error_out 0, ready exactly 28 cycles after acceptance.
  - 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated), error_out 0.
  - 0x3F800000 / 0x00000000 -> 0x7F800000, error_out 1; 0xBF800000 / 0x00000000 -> 0xFF800000, error_out 1.
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, error_out 1; 0x00800000 / 0x4B000000 -> 0x00000000, error_out 0.
  - 6/2 with error_in=1 -> 0x40400000, error_out 1; valid held high with changing operands during busy -> only the first operation completes.
  - rst=1 in DIV cycle 10 -> no ready pulse, all outputs 0 next cycle; 6/2 applied at the first edge with rst=0 -> 0x40400000 after 28 cycles.

Source files
------------

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider.
// Fixed 28-cycle latency from acceptance to the ready pulse: UNPACK (1), DIV (25),
// PACK (1), DONE (1). Rounding is truncation; subnormal inputs are treated as zero.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] float_in_1,
  input  logic [31:0] float_in_2,
  input  logic        error_in,
  output logic [31:0] float_out,
  output logic        ready,
  output logic        error_out,
  output logic        busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StUnpack = 3'd1;
  localparam logic [2:0] StDiv    = 3'd2;
  localparam logic [2:0] StPack   = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              err_in_q, err_in_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [23:0]       mb_q, mb_d;
  logic [24:0]       rem_q, rem_d;
  logic [24:0]       quo_q, quo_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              nan_q, nan_d, dbz_q, dbz_d, zero_q, zero_d;
  logic [31:0]       fout_q, fout_d;
  logic              eout_q, eout_d;

  // Scratch values used inside the next-state logic.
  logic [7:0]        ea, eb;
  logic              a_zero, b_zero;
  logic [25:0]       diff;
  logic signed [9:0] exp_f;
  logic [22:0]       frac;

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    err_in_d = err_in_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    nan_d    = nan_q;
    dbz_d    = dbz_q;
    zero_d   = zero_q;
    fout_d   = fout_q;
    eout_d   = eout_q;
    ea       = a_q[30:23];
    eb       = b_q[30:23];
    a_zero   = (ea == 8'd0);
    b_zero   = (eb == 8'd0);
    diff     = {1'b0, rem_q} - {2'b00, mb_q};
    exp_f    = quo_q[24] ? exp_q : exp_q - 10'sd1;
    frac     = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

    unique case (state_q)
      StIdle, StDone: begin
        // A new operation may also be taken on the edge that ends DONE.
        state_d = StIdle;
        if (valid) begin
          a_d      = float_in_1;
          b_d      = float_in_2;
          err_in_d = error_in;
          state_d  = StUnpack;
        end
      end
      StUnpack: begin
        sign_d = a_q[31] ^ b_q[31];
        exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        mb_d   = {1'b1, b_q[22:0]};
        // Ma < 2*Mb, so the first quotient bit is just Ma >= Mb.
        rem_d  = {2'b01, a_q[22:0]};
        quo_d  = '0;
        cnt_d  = '0;
        // Zero exponent covers both true zeros and flushed subnormals.
        nan_d  = (ea == 8'hFF) || (eb == 8'hFF) || (a_zero && b_zero);
        dbz_d  = b_zero && !a_zero;
        zero_d = a_zero;
        state_d = StDiv;
      end
      StDiv: begin
        // Restoring step: subtract divisor if it fits, then shift remainder.
        if (!diff[25]) begin
          quo_d = {quo_q[23:0], 1'b1};
          rem_d = diff[24:0] << 1;
        end else begin
          quo_d = {quo_q[23:0], 1'b0};
          rem_d = rem_q << 1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = StPack;
      end
      StPack: begin
        eout_d = err_in_q;
        if (nan_q) begin
          fout_d = 32'h7FC0_0000;
          eout_d = 1'b1;
        end else if (dbz_q) begin
          fout_d = {sign_q, 31'h7F80_0000};
          eout_d = 1'b1;
        end else if (zero_q) begin
          fout_d = {sign_q, 31'h0};
        end else if (exp_f >= 10'sd255) begin
          fout_d = {sign_q, 31'h7F80_0000};
          eout_d = 1'b1;
        end else if (exp_f <= 10'sd0) begin
          fout_d = {sign_q, 31'h0};
        end else begin
          fout_d = {sign_q, exp_f[7:0], frac};
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset wins over any pending operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      err_in_q <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      nan_q    <= 1'b0;
      dbz_q    <= 1'b0;
      zero_q   <= 1'b0;
      fout_q   <= '0;
      eout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      err_in_q <= err_in_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      nan_q    <= nan_d;
      dbz_q    <= dbz_d;
      zero_q   <= zero_d;
      fout_q   <= fout_d;
      eout_q   <= eout_d;
    end
  end

  assign float_out = fout_q;
  assign error_out = eout_q;
  assign ready     = (state_q == StDone);
  assign busy      = (state_q != StIdle);

endmodule
